four_bit_accumulator_sequencer: RTL and testbench

- Sequential stage wrapped around the 4-bit adder/subtractor.
- Holds a 4-bit accumulator, drives A = accumulator and B = command operand into an internal four_bit_adder_subtractor instance, and consumes Result/Cout back into the accumulator.
- Commands arrive over a valid/ready handshake; each completed command returns the accumulator and status flags over a second valid/ready handshake.
- This is the register/control layer that turns the combinational adder-subtractor into a usable arithmetic unit.

---
 rtl/four_bit_accumulator_sequencer.sv | 135 +++++++++++++
 tb/tb_four_bit_accumulator_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/four_bit_accumulator_sequencer.sv
// Accumulator sequencer: a 3-state command/response FSM around a combinational
// 4-bit adder/subtractor, with carry, zero, negative, overflow and op-count status.

module four_bit_adder_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       subtract,
  output logic [3:0] result,
  output logic       cout
);
  logic [3:0] b_eff;
  logic [4:0] sum;

  // Two's complement of b is formed mod 16 first, so subtracting zero never carries.
  always_comb begin
    b_eff = subtract ? (~b + 4'd1) : b;
    sum   = {1'b0, a} + {1'b0, b_eff};
  end

  assign result = sum[3:0];
  assign cout   = sum[4];
endmodule

module four_bit_accumulator_sequencer #(
  parameter bit OVF_STICKY = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Cmd_valid,
  output logic       Cmd_ready,
  input  logic [1:0] Cmd_op,
  input  logic [3:0] Cmd_data,
  output logic       Rsp_valid,
  input  logic       Rsp_ready,
  output logic [3:0] Acc,
  output logic       Carry,
  output logic       Zero,
  output logic       Neg,
  output logic       Ovf,
  output logic [3:0] Op_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  logic [1:0] state;
  logic [1:0] op_p0;
  logic [3:0] operand_p0;
  logic [3:0] acc;
  logic       carry;
  logic       ovf;
  logic [3:0] op_count;
  logic [3:0] sum_result;
  logic       sum_cout;
  logic       new_ovf;

  // Signed overflow judged on the operand as given, so 0 - (-8) is flagged.
  function automatic logic signed_ovf(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] r, input logic sub);
    if (sub)
      return (a[3] != b[3]) && (r[3] != a[3]);
    else
      return (a[3] == b[3]) && (r[3] != a[3]);
  endfunction

  four_bit_adder_subtractor u_addsub (
    .a        (acc),
    .b        (operand_p0),
    .subtract (op_p0 == OP_SUB),
    .result   (sum_result),
    .cout     (sum_cout)
  );

  assign new_ovf = signed_ovf(acc, operand_p0, sum_result, op_p0 == OP_SUB);

  // Stage p0: command capture; data-only registers, no reset needed.
  always_ff @(posedge Clk) begin
    if (state == IDLE && Cmd_valid) begin
      op_p0      <= Cmd_op;
      operand_p0 <= Cmd_data;
    end
  end

  // Stage p1: execute and hold the response until it is taken.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      acc      <= 4'd0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      op_count <= 4'd0;
    end else begin
      case (state)
        IDLE: if (Cmd_valid) state <= EXEC;
        EXEC: begin
          case (op_p0)
            OP_CLEAR: begin
              acc   <= 4'd0;
              carry <= 1'b0;
              ovf   <= 1'b0;
            end
            OP_LOAD: begin
              acc   <= operand_p0;
              carry <= 1'b0;
              ovf   <= 1'b0;
            end
            default: begin
              acc   <= sum_result;
              carry <= sum_cout;
              ovf   <= OVF_STICKY ? (ovf | new_ovf) : new_ovf;
            end
          endcase
          op_count <= op_count + 4'd1;
          state    <= RESP;
        end
        RESP: if (Rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Cmd_ready = (state == IDLE);
  assign Rsp_valid = (state == RESP);
  assign Acc       = acc;
  assign Carry     = carry;
  assign Zero      = (acc == 4'd0);
  assign Neg       = acc[3];
  assign Ovf       = ovf;
  assign Op_count  = op_count;
endmodule

// File: tb/tb_four_bit_accumulator_sequencer.sv
// Directed bench for the accumulator sequencer: handshake timing, op results,
// flags, backpressure, reset during a pending response and op-count wrap.

module tb_four_bit_accumulator_sequencer;
  localparam logic [1:0] CLEAR = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] ADD   = 2'b10;
  localparam logic [1:0] SUB   = 2'b11;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Cmd_valid;
  logic       Cmd_ready;
  logic [1:0] Cmd_op;
  logic [3:0] Cmd_data;
  logic       Rsp_valid;
  logic       Rsp_ready;
  logic [3:0] Acc;
  logic       Carry;
  logic       Zero;
  logic       Neg;
  logic       Ovf;
  logic [3:0] Op_count;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_cnt;

  four_bit_accumulator_sequencer #(.OVF_STICKY(1'b1)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Cmd_valid (Cmd_valid),
    .Cmd_ready (Cmd_ready),
    .Cmd_op    (Cmd_op),
    .Cmd_data  (Cmd_data),
    .Rsp_valid (Rsp_valid),
    .Rsp_ready (Rsp_ready),
    .Acc       (Acc),
    .Carry     (Carry),
    .Zero      (Zero),
    .Neg       (Neg),
    .Ovf       (Ovf),
    .Op_count  (Op_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] acc, input logic c,
                           input logic z, input logic n, input logic o);
    chk({tag, "_acc"},   Acc,      acc);
    chk({tag, "_carry"}, {3'b0, Carry}, {3'b0, c});
    chk({tag, "_zero"},  {3'b0, Zero},  {3'b0, z});
    chk({tag, "_neg"},   {3'b0, Neg},   {3'b0, n});
    chk({tag, "_ovf"},   {3'b0, Ovf},   {3'b0, o});
    chk({tag, "_cnt"},   Op_count, exp_cnt);
  endtask

  // Issue one command and leave the DUT holding its response (Rsp_ready low).
  // The inputs are scrambled right after acceptance to prove the latched copy is used.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data);
    int n;
    n = 0;
    @(negedge Clk);
    Cmd_valid = 1'b1;
    Cmd_op    = op;
    Cmd_data  = data;
    while (!Cmd_ready && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("accept_timeout", {3'b0, n < 10}, 4'd1);
    @(posedge Clk);
    #1;
    Cmd_valid = 1'b0;
    Cmd_op    = ~op;
    Cmd_data  = ~data;
    chk("exec_ready",  {3'b0, Cmd_ready}, 4'd0);
    chk("exec_rvalid", {3'b0, Rsp_valid}, 4'd0);
    exp_cnt = exp_cnt + 4'd1;
    @(posedge Clk);
    #1;
    chk("resp_rvalid", {3'b0, Rsp_valid}, 4'd1);
  endtask

  task automatic finish_rsp();
    @(negedge Clk);
    Rsp_ready = 1'b1;
    @(posedge Clk);
    #1;
    Rsp_ready = 1'b0;
    chk("idle_rvalid", {3'b0, Rsp_valid}, 4'd0);
    chk("idle_ready",  {3'b0, Cmd_ready}, 4'd1);
  endtask

  initial begin
    Reset     = 1'b1;
    Cmd_valid = 1'b0;
    Cmd_op    = 2'b00;
    Cmd_data  = 4'h0;
    Rsp_ready = 1'b0;
    exp_cnt   = 4'd0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_rsp("reset", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_ready",  {3'b0, Cmd_ready}, 4'd1);
    chk("reset_rvalid", {3'b0, Rsp_valid}, 4'd0);

    run_cmd(LOAD, 4'h3); check_rsp("load3", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0); finish_rsp();
    run_cmd(ADD, 4'h4);  check_rsp("add4",  4'h7, 1'b0, 1'b0, 1'b0, 1'b0); finish_rsp();

    run_cmd(LOAD, 4'h7); check_rsp("load7", 4'h7, 1'b0, 1'b0, 1'b0, 1'b0); finish_rsp();
    run_cmd(ADD, 4'h1);  check_rsp("ovf_add", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1); finish_rsp();
    run_cmd(ADD, 4'h0);  check_rsp("sticky", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1); finish_rsp();
    run_cmd(CLEAR, 4'h5); check_rsp("clear", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0); finish_rsp();

    run_cmd(LOAD, 4'h5); finish_rsp();
    run_cmd(SUB, 4'h3);  check_rsp("sub53", 4'h2, 1'b1, 1'b0, 1'b0, 1'b0); finish_rsp();
    run_cmd(LOAD, 4'h3); finish_rsp();
    run_cmd(SUB, 4'h5);  check_rsp("sub35", 4'hE, 1'b0, 1'b0, 1'b1, 1'b0); finish_rsp();
    run_cmd(LOAD, 4'h0); finish_rsp();
    run_cmd(SUB, 4'h8);  check_rsp("sub08", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1); finish_rsp();
    run_cmd(LOAD, 4'hF); finish_rsp();
    run_cmd(ADD, 4'h1);  check_rsp("addF1", 4'h0, 1'b1, 1'b1, 1'b0, 1'b0); finish_rsp();
    run_cmd(LOAD, 4'h5); finish_rsp();
    run_cmd(SUB, 4'h0);  check_rsp("sub50", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0); finish_rsp();

    // Backpressure: response held while the command inputs churn.
    run_cmd(LOAD, 4'hA); check_rsp("bp_load", 4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      Cmd_valid = i[0];
      Cmd_op    = i[1:0];
      Cmd_data  = i[3:0] + 4'd1;
      @(posedge Clk);
      #1;
      chk("bp_ready",  {3'b0, Cmd_ready}, 4'd0);
      chk("bp_rvalid", {3'b0, Rsp_valid}, 4'd1);
      chk("bp_acc",    Acc, 4'hA);
      chk("bp_cnt",    Op_count, exp_cnt);
    end
    @(negedge Clk);
    Cmd_valid = 1'b1;
    Cmd_op    = LOAD;
    Cmd_data  = 4'h9;
    Rsp_ready = 1'b1;
    @(posedge Clk);
    #1;
    Rsp_ready = 1'b0;
    chk("bp_rel_ready", {3'b0, Cmd_ready}, 4'd1);
    chk("bp_rel_acc",   Acc, 4'hA);
    @(posedge Clk);
    #1;
    Cmd_valid = 1'b0;
    chk("bp_acc_ready", {3'b0, Cmd_ready}, 4'd0);
    exp_cnt = exp_cnt + 4'd1;
    @(posedge Clk);
    #1;
    chk("bp_rvalid2", {3'b0, Rsp_valid}, 4'd1);
    check_rsp("bp_held", 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_rsp();

    // Reset while a response is pending.
    run_cmd(ADD, 4'h1);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset   = 1'b0;
    exp_cnt = 4'd0;
    check_rsp("rst_resp", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_resp_ready",  {3'b0, Cmd_ready}, 4'd1);
    chk("rst_resp_rvalid", {3'b0, Rsp_valid}, 4'd0);

    // Op count wraps after sixteen commands.
    for (int i = 1; i <= 17; i++) begin
      run_cmd(LOAD, 4'(i));
      chk("wrap_acc", Acc, 4'(i));
      chk("wrap_cnt", Op_count, exp_cnt);
      finish_rsp();
    end
    chk("wrap_final", Op_count, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
